// File: rtl/vm_evnt_ctl_if.sv
// Event/status handshake bundle between the CPU side (master) and vm_evnt_ctl (slave).
interface vm_evnt_ctl_if;
    logic timer_status;
    logic status_wr;
    logic status_wd;
    logic evnt_req;
    logic evnt_ack;
    logic evnt_ovr;
    logic ovr_clr;

    modport master (
        input  timer_status, evnt_req, evnt_ovr,
        output status_wr, status_wd, evnt_ack, ovr_clr
    );

    modport slave (
        output timer_status, evnt_req, evnt_ovr,
        input  status_wr, status_wd, evnt_ack, ovr_clr
    );
endinterface

// File: rtl/vm_evnt_ctl.sv
// Event tick generator, tick-enabled button debouncer, latched event request and CPU clock enable.
// Optional macro EVNT_OVR_EN adds the sticky evnt_ovr overrun flag; without it evnt_ovr is tied low.
module vm_evnt_ctl #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned EVT_HZ      = 50,
    parameter int unsigned DEB_LEN     = 2,
    parameter int unsigned SLOW_DIV    = 22,
    parameter bit          STATUS_INIT = 1'b0
) (
    input  logic            clk_p,
    input  logic            rst_n,
    input  logic            cpuslow,
    output logic            clk_ena,
    input  logic            timer_button,
    output logic            tick,
    vm_evnt_ctl_if.slave    bus
);
    localparam int unsigned DIV = CLK_HZ / EVT_HZ;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DW  = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

    typedef enum logic [0:0] {ARMED = 1'b0, LOCKED = 1'b1} deb_state_e;

    logic [CW-1:0]      tick_cnt_q, tick_cnt_d;
    logic               tick_q, tick_d;
    logic [DW-1:0]      div_cnt_q, div_cnt_d;
    logic               clk_ena_q, clk_ena_d;
    logic               btn_meta_q, btn_sync_q;
    logic [DEB_LEN-1:0] deb_sr_q, deb_sr_d;
    logic [DEB_LEN:0]   deb_shift_s;
    deb_state_e         state_q, state_d;
    logic               status_q, status_d;
    logic               toggle_s;
    logic               evnt_set_s;
    logic               evnt_req_q, evnt_req_d;

    // Tick period counter and the free-running CPU divider; both always count.
    always_comb begin
        tick_cnt_d = (tick_cnt_q == CW'(DIV - 1)) ? {CW{1'b0}} : tick_cnt_q + CW'(1);
        tick_d     = (tick_cnt_q == CW'(DIV - 1));
        div_cnt_d  = (div_cnt_q == DW'(SLOW_DIV - 1)) ? {DW{1'b0}} : div_cnt_q + DW'(1);
        clk_ena_d  = ~cpuslow | (div_cnt_q == DW'(SLOW_DIV - 1));
    end

    // Debounce FSM: a software write overrides the button toggle but not the lockout.
    always_comb begin
        deb_shift_s = {deb_sr_q, btn_sync_q};
        deb_sr_d    = tick_q ? deb_shift_s[DEB_LEN-1:0] : deb_sr_q;
        toggle_s    = 1'b0;
        case (state_q)
            ARMED: begin
                if (&deb_sr_q) begin
                    toggle_s = 1'b1;
                    state_d  = LOCKED;
                end else begin
                    state_d  = ARMED;
                end
            end
            LOCKED: begin
                if (~|deb_sr_q) begin
                    state_d = ARMED;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: state_d = ARMED;
        endcase
        status_d = bus.status_wr ? bus.status_wd : (toggle_s ? ~status_q : status_q);
    end

    // A qualifying tick always wins over an acknowledge in the same cycle.
    always_comb begin
        evnt_set_s = tick_q & status_q;
        evnt_req_d = evnt_set_s | (evnt_req_q & ~bus.evnt_ack);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= {CW{1'b0}};
            tick_q     <= 1'b0;
            div_cnt_q  <= {DW{1'b0}};
            clk_ena_q  <= 1'b0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            deb_sr_q   <= {DEB_LEN{1'b0}};
            state_q    <= ARMED;
            status_q   <= STATUS_INIT;
            evnt_req_q <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            div_cnt_q  <= div_cnt_d;
            clk_ena_q  <= clk_ena_d;
            btn_meta_q <= timer_button;
            btn_sync_q <= btn_meta_q;
            deb_sr_q   <= deb_sr_d;
            state_q    <= state_d;
            status_q   <= status_d;
            evnt_req_q <= evnt_req_d;
        end
    end

`ifdef EVNT_OVR_EN
    logic ovr_set_s;
    logic evnt_ovr_q, evnt_ovr_d;

    // Overrun: a new event lands on an unacknowledged one; setting beats clearing.
    always_comb begin
        ovr_set_s  = evnt_set_s & evnt_req_q & ~bus.evnt_ack;
        evnt_ovr_d = ovr_set_s ? 1'b1 : (bus.ovr_clr ? 1'b0 : evnt_ovr_q);
    end

    // Sticky overrun register.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            evnt_ovr_q <= 1'b0;
        end else begin
            evnt_ovr_q <= evnt_ovr_d;
        end
    end

    assign bus.evnt_ovr = evnt_ovr_q;
`else
    assign bus.evnt_ovr = 1'b0;
`endif

    assign tick             = tick_q;
    assign clk_ena          = clk_ena_q;
    assign bus.timer_status = status_q;
    assign bus.evnt_req     = evnt_req_q;
endmodule

// File: tb/tb_vm_evnt_ctl.sv
// Randomized bench for vm_evnt_ctl checked cycle by cycle against an arithmetic/queue reference model.
module tb_vm_evnt_ctl;
    localparam int unsigned CLK_HZ   = 1000;
    localparam int unsigned EVT_HZ   = 100;
    localparam int unsigned DEB_LEN  = 2;
    localparam int unsigned SLOW_DIV = 22;
    localparam int          DIV      = CLK_HZ / EVT_HZ;

    logic clk_p = 1'b0;
    logic rst_n = 1'b0;
    logic cpuslow = 1'b0;
    logic timer_button = 1'b0;
    logic clk_ena0, tick0, clk_ena1, tick1;

    vm_evnt_ctl_if bus0 ();
    vm_evnt_ctl_if bus1 ();

    assign bus1.status_wr = bus0.status_wr;
    assign bus1.status_wd = bus0.status_wd;
    assign bus1.evnt_ack  = bus0.evnt_ack;
    assign bus1.ovr_clr   = bus0.ovr_clr;

    vm_evnt_ctl #(.CLK_HZ(CLK_HZ), .EVT_HZ(EVT_HZ), .DEB_LEN(DEB_LEN),
                  .SLOW_DIV(SLOW_DIV), .STATUS_INIT(1'b0)) dut0 (
        .clk_p(clk_p), .rst_n(rst_n), .cpuslow(cpuslow), .clk_ena(clk_ena0),
        .timer_button(timer_button), .tick(tick0), .bus(bus0));

    vm_evnt_ctl #(.CLK_HZ(CLK_HZ), .EVT_HZ(EVT_HZ), .DEB_LEN(DEB_LEN),
                  .SLOW_DIV(SLOW_DIV), .STATUS_INIT(1'b1)) dut1 (
        .clk_p(clk_p), .rst_n(rst_n), .cpuslow(cpuslow), .clk_ena(clk_ena1),
        .timer_button(timer_button), .tick(tick1), .bus(bus1));

    always #5 clk_p = ~clk_p;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state as seen after the most recent rising edge.
    int m_cyc;
    bit m_tick, m_ena, m_status, m_armed, m_req, m_ovr;
    bit m_btn_lag[$];
    bit m_smp[$];

    task automatic model_reset();
        m_cyc = 0; m_tick = 0; m_ena = 0; m_status = 0;
        m_armed = 1; m_req = 0; m_ovr = 0;
        m_btn_lag = {};
        m_btn_lag.push_back(1'b0);
        m_btn_lag.push_back(1'b0);
        m_smp = {};
        for (int i = 0; i < DEB_LEN; i++) m_smp.push_back(1'b0);
    endtask

    task automatic model_advance();
        int  ones;
        bit  set_evt, toggle, new_status;
        ones = 0;
        foreach (m_smp[i]) if (m_smp[i]) ones++;
        set_evt    = m_tick && m_status;
        toggle     = m_armed && (ones == DEB_LEN);
        new_status = bus0.status_wr ? bus0.status_wd : (toggle ? !m_status : m_status);
        if (toggle) m_armed = 0;
        else if (!m_armed && ones == 0) m_armed = 1;
`ifdef EVNT_OVR_EN
        m_ovr = (set_evt && m_req && !bus0.evnt_ack) || (m_ovr && !bus0.ovr_clr);
`else
        m_ovr = 0;
`endif
        m_req = set_evt || (m_req && !bus0.evnt_ack);
        if (m_tick) begin
            m_smp.push_back(m_btn_lag[0]);
            void'(m_smp.pop_front());
        end
        void'(m_btn_lag.pop_front());
        m_btn_lag.push_back(timer_button);
        m_cyc++;
        m_ena    = !cpuslow || (m_cyc % SLOW_DIV == 0);
        m_tick   = (m_cyc % DIV == 0);
        m_status = new_status;
    endtask

    task automatic check_all();
        check_bit("tick", tick0, m_tick);
        check_bit("clk_ena", clk_ena0, m_ena);
        check_bit("timer_status", bus0.timer_status, m_status);
        check_bit("evnt_req", bus0.evnt_req, m_req);
        check_bit("evnt_ovr", bus0.evnt_ovr, m_ovr);
        if (m_cyc == 10 || m_cyc == 20 || m_cyc == 30) check_bit("tick_on_period", tick0, 1'b1);
    endtask

    // One clock: check at the falling edge, drive new inputs, step the model.
    task automatic run_cycle(input bit btn, input bit cs, input bit swr, input bit swd,
                             input bit ack, input bit clr);
        check_all();
        timer_button   = btn;
        cpuslow        = cs;
        bus0.status_wr = swr;
        bus0.status_wd = swd;
        bus0.evnt_ack  = ack;
        bus0.ovr_clr   = clr;
        model_advance();
        @(negedge clk_p);
    endtask

    task automatic check_reset_values();
        check_bit("rst_tick", tick0, 1'b0);
        check_bit("rst_clk_ena", clk_ena0, 1'b0);
        check_bit("rst_status", bus0.timer_status, 1'b0);
        check_bit("rst_req", bus0.evnt_req, 1'b0);
        check_bit("rst_ovr", bus0.evnt_ovr, 1'b0);
        check_bit("rst_status_init1", bus1.timer_status, 1'b1);
    endtask

    bit btn_r;
    bit cs_r;
    int hold;

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            if (hold == 0) begin
                btn_r = !btn_r;
                hold  = $urandom_range(2, 70);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 39) == 0) cs_r = !cs_r;
            run_cycle(btn_r, cs_r, ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
        end
    endtask

    initial begin
        timer_button = 1'b0; cpuslow = 1'b0;
        bus0.status_wr = 1'b0; bus0.status_wd = 1'b0;
        bus0.evnt_ack = 1'b0; bus0.ovr_clr = 1'b0;
        btn_r = 1'b0; cs_r = 1'b0; hold = 40;
        model_reset();
        repeat (3) @(negedge clk_p);
        check_reset_values();
        rst_n = 1'b1;

        // Enable the timer by software, then never acknowledge: request then overrun.
        run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Acknowledge exactly on tick cycles.
        for (int i = 0; i < 25; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, m_tick, 1'b0);
        // Slow mode, then back to full speed.
        for (int i = 0; i < 50; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Button held well beyond the debounce window, released, pressed again.
        for (int i = 0; i < 60; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Short glitches that never span a full debounce window.
        for (int i = 0; i < 60; i++) run_cycle((i % 8) < 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        run_random(3000);

        // Reset pulsed mid-period and mid-debounce.
        for (int i = 0; i < 15; i++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk_p);
        check_reset_values();
        model_reset();
        rst_n = 1'b1;
        run_random(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
